// File: rtl/mask_pkg.sv
// Shared types and helpers for the row-mask scheduler; `nStates sets the mask word width.
// Combinational helpers only: no latency and no backpressure of their own.
`ifndef nStates
`define nStates 4
`endif

package mask_pkg;

    localparam int unsigned MASK_W = `nStates;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DONE
    } mask_sched_state_t;

    function automatic logic [MASK_W-1:0] onehot_mask(input logic [31:0] idx);
        return MASK_W'(1) << idx;
    endfunction

endpackage

// File: rtl/mask_scheduler_if.sv
// Bundle between layer controller, scheduler and datapath mask input; row_en exists only with MASK_SKIP_EN.
// Wires only: latency and mask_valid/mask_ready backpressure are set by the scheduler.
interface mask_scheduler_if #(
    parameter int R  = 3,
    parameter int CW = $clog2(R+1)
);
    import mask_pkg::*;

    logic                 start;
    logic [CW-1:0]        rows_active;
`ifdef MASK_SKIP_EN
    logic [R-1:0]         row_en;
`endif
    logic [MASK_W-1:0]    mask_out;
    logic                 mask_valid;
    logic                 mask_ready;
    logic                 busy;
    logic                 done;
    logic                 err;

    // Scheduler side.
    modport slave (
        input  start, rows_active,
`ifdef MASK_SKIP_EN
        input  row_en,
`endif
        input  mask_ready,
        output mask_out, mask_valid, busy, done, err
    );

    // Controller / datapath side.
    modport master (
        output start, rows_active,
`ifdef MASK_SKIP_EN
        output row_en,
`endif
        output mask_ready,
        input  mask_out, mask_valid, busy, done, err
    );

endinterface

// File: rtl/mask_scheduler_next_row_finder.sv
// Priority encoder: lowest enabled row k with from <= k < limit (MASK_SKIP_EN builds only).
// Purely combinational, no backpressure.
module mask_scheduler_next_row_finder #(
    parameter int R  = 3,
    parameter int CW = $clog2(R+1)
) (
    input  logic [R-1:0]  row_en,
    input  logic [CW-1:0] from,
    input  logic [CW-1:0] limit,
    output logic          found,
    output logic [CW-1:0] idx
);

    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int k = R-1; k >= 0; k--) begin
            if (row_en[k] && (k >= int'(from)) && (k < int'(limit))) begin
                found = 1'b1;
                idx   = CW'(k);
            end
        end
    end

endmodule

// File: rtl/mask_scheduler.sv
// Row-mask sequencer: one one-hot mask beat per active row; first beat 1 cycle after start, done 1 cycle after last accept.
// Beats held stable while mask_ready is low; MASK_SKIP_EN enables skipping rows with row_en=0.
module mask_scheduler
    import mask_pkg::*;
#(
    parameter int R  = 3,
    parameter int CW = $clog2(R+1)
) (
    input  logic            clk,
    input  logic            rst_n,
    mask_scheduler_if.slave bus
);

    if (MASK_W < R) begin : g_width_check
        $error("mask_scheduler: `nStates must be >= R");
    end

    mask_sched_state_t state_q, state_d;
    logic [CW-1:0]     idx_q, idx_d;
    logic [CW-1:0]     limit_q, limit_d;
    logic [MASK_W-1:0] mask_out_q, mask_out_d;
    logic              mask_valid_q, mask_valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              last;
    logic [CW-1:0]     next_idx;
    logic              range_ok;

`ifdef MASK_SKIP_EN
    logic [R-1:0]  row_en_q, row_en_d;
    logic [R-1:0]  fnd_row_en;
    logic [CW-1:0] fnd_from, fnd_limit, fnd_idx;
    logic          fnd_found;

    // One finder serves both the start lookup and the per-accept lookup.
    always_comb begin
        fnd_row_en = row_en_q;
        fnd_from   = idx_q + 1'b1;
        fnd_limit  = limit_q;
        if (state_q == IDLE) begin
            fnd_row_en = bus.row_en;
            fnd_from   = '0;
            fnd_limit  = bus.rows_active;
        end
    end

    mask_scheduler_next_row_finder #(.R(R), .CW(CW)) u_finder (
        .row_en (fnd_row_en),
        .from   (fnd_from),
        .limit  (fnd_limit),
        .found  (fnd_found),
        .idx    (fnd_idx)
    );

    assign last     = !fnd_found;
    assign next_idx = fnd_idx;
`else
    assign last     = (idx_q == limit_q - 1'b1);
    assign next_idx = idx_q + 1'b1;
`endif

    assign range_ok = (bus.rows_active != '0) && (int'(bus.rows_active) <= R);

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        limit_d      = limit_q;
        mask_out_d   = mask_out_q;
        mask_valid_d = mask_valid_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        err_d        = 1'b0;
`ifdef MASK_SKIP_EN
        row_en_d     = row_en_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (!range_ok) begin
                        err_d = 1'b1;
                    end else begin
                        limit_d = bus.rows_active;
`ifdef MASK_SKIP_EN
                        row_en_d = bus.row_en;
                        if (fnd_found) begin
                            state_d      = ISSUE;
                            idx_d        = fnd_idx;
                            mask_out_d   = onehot_mask(32'(fnd_idx));
                            mask_valid_d = 1'b1;
                            busy_d       = 1'b1;
                        end else begin
                            // Nothing enabled: finish the sweep without issuing a beat.
                            state_d = DONE;
                            idx_d   = '0;
                            busy_d  = 1'b1;
                            done_d  = 1'b1;
                        end
`else
                        state_d      = ISSUE;
                        idx_d        = '0;
                        mask_out_d   = onehot_mask(32'd0);
                        mask_valid_d = 1'b1;
                        busy_d       = 1'b1;
`endif
                    end
                end
            end
            ISSUE: begin
                if (mask_valid_q && bus.mask_ready) begin
                    if (last) begin
                        state_d      = DONE;
                        mask_out_d   = '0;
                        mask_valid_d = 1'b0;
                        done_d       = 1'b1;
                    end else begin
                        idx_d      = next_idx;
                        mask_out_d = onehot_mask(32'(next_idx));
                    end
                end
            end
            DONE: begin
                state_d      = IDLE;
                idx_d        = '0;
                mask_out_d   = '0;
                mask_valid_d = 1'b0;
                busy_d       = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            limit_q      <= '0;
            mask_out_q   <= '0;
            mask_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
`ifdef MASK_SKIP_EN
            row_en_q     <= '0;
`endif
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            limit_q      <= limit_d;
            mask_out_q   <= mask_out_d;
            mask_valid_q <= mask_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
`ifdef MASK_SKIP_EN
            row_en_q     <= row_en_d;
`endif
        end
    end

    assign bus.mask_out   = mask_out_q;
    assign bus.mask_valid = mask_valid_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;

endmodule
